alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//   Result capture stage directly downstream of the ALU datapath (rotate/shift/logic/arith/mul/div).
//   Registers each ALU result pair (Z high/low) with status flags into a small FIFO.
//   Presents entries to the bus-side Z register consumer via valid/ready.
//   Decouples single-cycle ALU ops from multi-cycle bus write-back; no result is ever dropped.
// PARAMETERS
//   DATA_W  32  width of each result half (lo and hi)
//   DEPTH   2   FIFO entries; power of two, >= 2
//   OP_W    5   width of ALU opcode tag carried with each result
// PORTS
//   clock      in   1       rising-edge clock
//   clear      in   1       synchronous, active-high reset
//   in_valid   in   1       ALU result available this cycle
//   in_ready   out  1       stage can accept a result this cycle
//   in_lo      in   DATA_W  result low word (e.g. rotate/shift/add output)
//   in_hi      in   DATA_W  result high word (mul product high / div remainder)
//   in_wide    in   1       1 = op produces hi word; 0 = hi is don't-care
//   in_op      in   OP_W    opcode tag of the producing operation
//   out_valid  out  1       head entry valid
//   out_ready  in   1       consumer takes head entry this cycle
//   out_lo     out  DATA_W  head entry low word (ZLO)
//   out_hi     out  DATA_W  head entry high word (ZHI)
//   out_op     out  OP_W    head entry opcode tag
//   out_zero   out  1       head entry zero flag
//   out_neg    out  1       head entry negative flag
//   count      out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//   - Push when in_valid & in_ready; pop when out_valid & out_ready; both evaluated at clock rising edge.
//   - in_ready = (count < DEPTH); registered-state only, never combinationally depends on out_ready.
//   - out_valid = (count != 0). out_lo/out_hi/out_op/out_zero/out_neg driven from head entry.
//   - Latency: a push into an empty FIFO gives out_valid=1 with that data on the next cycle.
//   - Head outputs are stable while out_valid & !out_ready.
//   - Store rule: if in_wide=0, stored hi is forced to 0.
//   - Flags are computed at push time and stored:
//       zero = (in_lo==0) & (in_wide ? in_hi==0 : 1)
//       neg  = in_wide ? in_hi[DATA_W-1] : in_lo[DATA_W-1]
//   - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//   - Push and pop in the same cycle:
//       count unchanged; head advances; new entry written at tail.
//       Not possible when full, because in_ready=0 there.
//   - Full: in_valid is ignored and in_lo/in_hi are not sampled.
//   - Empty: out_ready is ignored; count never underflows.
//   - Reset, including mid-operation:
//       pointers=0, count=0, out_valid=0, in_ready=1 (from next cycle).
//       Storage and head outputs read 0; all pending entries are discarded.
//   - clear has priority over simultaneous push/pop in the same cycle.
//   - No combinational path from in_* to out_*.
// TESTING
//   1. clear=1 for 2 cycles -> count=0, out_valid=0, in_ready=1, out_lo=out_hi=0.
//   2. Push lo=32'h8000_0001, wide=0, op=5'd7 into empty FIFO
//      -> next cycle out_valid=1, out_lo=32'h8000_0001, out_hi=0, neg=1, zero=0, op=7.
//   3. Push lo=0, hi=0, wide=1, then lo=0, hi=1, wide=1 with out_ready=0
//      -> count=2, in_ready=0; a third push attempt is ignored.
//      Pop twice -> entry 1 has zero=1; entry 2 has zero=0, neg=0.
//   4. count=1 and push+pop in the same cycle for 6 consecutive cycles
//      -> count stays 1, data emerges in order, pointer wrap verified.
//   5. FIFO full and clear asserted together with out_ready=1, in_valid=1
//      -> next cycle count=0, out_valid=0, nothing popped or pushed.
//   6. Random valid/ready (10k cycles) vs scoreboard
//      -> in-order, no loss/duplication, head stable under stall.

Source files
------------

// File: rtl/alu_result_stage.sv
// Result capture FIFO between the ALU datapath and the bus-side Z register consumer.
// Each entry holds the lo/hi result words, opcode tag, and zero/negative flags computed at push.
module alu_result_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned OP_W   = 5
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_lo,
    input  logic [DATA_W-1:0]        in_hi,
    input  logic                     in_wide,
    input  logic [OP_W-1:0]          in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_lo,
    output logic [DATA_W-1:0]        out_hi,
    output logic [OP_W-1:0]          out_op,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] lo;
        logic [DATA_W-1:0] hi;
        logic [OP_W-1:0]   op;
        logic              zero;
        logic              neg;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           new_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // Handshakes depend only on registered occupancy, never on the opposite side.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        new_entry      = '0;
        new_entry.lo   = in_lo;
        new_entry.hi   = in_wide ? in_hi : '0;
        new_entry.op   = in_op;
        new_entry.zero = (in_lo == '0) && (!in_wide || (in_hi == '0));
        new_entry.neg  = in_wide ? in_hi[DATA_W-1] : in_lo[DATA_W-1];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= new_entry;
            end
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign out_lo   = head.lo;
    assign out_hi   = head.hi;
    assign out_op   = head.op;
    assign out_zero = head.zero;
    assign out_neg  = head.neg;
    assign count    = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed vector table plus a randomized scoreboard run for alu_result_stage.
module tb_alu_result_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned NVEC   = 18;

    logic              clock = 1'b0;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_lo;
    logic [DATA_W-1:0] in_hi;
    logic              in_wide;
    logic [OP_W-1:0]   in_op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_lo;
    logic [DATA_W-1:0] out_hi;
    logic [OP_W-1:0]   out_op;
    logic              out_zero;
    logic              out_neg;
    logic [1:0]        count;

    int checks   = 0;
    int failures = 0;

    alu_result_stage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .OP_W   (OP_W)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_lo     (in_lo),
        .in_hi     (in_hi),
        .in_wide   (in_wide),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lo    (out_lo),
        .out_hi    (out_hi),
        .out_op    (out_op),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .count     (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        clr;
        logic        iv;
        logic        ordy;
        logic        wide;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [4:0]  op;
        logic [1:0]  e_cnt;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_lo;
        logic [31:0] e_hi;
        logic [4:0]  e_op;
        logic        e_z;
        logic        e_n;
    } vec_t;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [4:0]  op;
        logic        z;
        logic        n;
    } ent_t;

    vec_t vecs [NVEC];
    ent_t sb [$];

    function automatic vec_t v(input logic clr, input logic iv, input logic ordy,
                               input logic wide, input logic [31:0] lo, input logic [31:0] hi,
                               input logic [4:0] op, input logic [1:0] cnt, input logic ov,
                               input logic ir, input logic [31:0] elo, input logic [31:0] ehi,
                               input logic [4:0] eop, input logic ez, input logic en);
        vec_t r;
        r.clr = clr; r.iv = iv; r.ordy = ordy; r.wide = wide;
        r.lo = lo; r.hi = hi; r.op = op;
        r.e_cnt = cnt; r.e_ov = ov; r.e_ir = ir;
        r.e_lo = elo; r.e_hi = ehi; r.e_op = eop; r.e_z = ez; r.e_n = en;
        return r;
    endfunction

    function automatic ent_t model_entry(input logic [31:0] lo, input logic [31:0] hi,
                                         input logic wide, input logic [4:0] op);
        ent_t e;
        e.lo = lo;
        e.hi = wide ? hi : 32'h0;
        e.op = op;
        e.z  = (lo == 32'h0) && (wide ? (hi == 32'h0) : 1'b1);
        e.n  = wide ? hi[31] : lo[31];
        return e;
    endfunction

    function automatic logic [75:0] pack_out(input logic [1:0] c, input logic ov,
                                             input logic ir, input logic [31:0] lo,
                                             input logic [31:0] hi, input logic [4:0] op,
                                             input logic z, input logic n);
        return {c, ov, ir, lo, hi, op, z, n};
    endfunction

    task automatic compare(input string name, input logic [75:0] got, input logic [75:0] exp,
                           input logic [75:0] mask);
        checks++;
        if ((got & mask) !== (exp & mask)) begin
            failures++;
            $display("FAIL %s: got cnt/ov/ir/lo/hi/op/z/n=%h required=%h mask=%h",
                     name, got, exp, mask);
        end
    endtask

    initial begin
        logic [75:0] got, exp, mask;
        logic        do_push, do_pop;
        ent_t        e;

        clear = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_lo = '0; in_hi = '0; in_wide = 1'b0; in_op = '0;

        // Reset, first push latency, store rule, fill/full, wrap under push+pop, clear when full.
        vecs[0]  = v(1,0,0,0, 32'h0, 32'h0, 5'd0, 2'd0,0,1, 32'h0, 32'h0, 5'd0, 0,0);
        vecs[1]  = v(1,0,0,0, 32'h0, 32'h0, 5'd0, 2'd0,0,1, 32'h0, 32'h0, 5'd0, 0,0);
        vecs[2]  = v(0,1,0,0, 32'h8000_0001, 32'hDEAD_BEEF, 5'd7, 2'd1,1,1,
                     32'h8000_0001, 32'h0, 5'd7, 0,1);
        vecs[3]  = v(0,0,1,0, 32'h0, 32'h0, 5'd0, 2'd0,0,1, 32'h0, 32'h0, 5'd0, 0,0);
        vecs[4]  = v(0,1,0,1, 32'h0, 32'h0, 5'd3, 2'd1,1,1, 32'h0, 32'h0, 5'd3, 1,0);
        vecs[5]  = v(0,1,0,1, 32'h0, 32'h1, 5'd4, 2'd2,1,0, 32'h0, 32'h0, 5'd3, 1,0);
        vecs[6]  = v(0,1,0,1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 2'd2,1,0,
                     32'h0, 32'h0, 5'd3, 1,0);
        vecs[7]  = v(0,0,1,0, 32'h0, 32'h0, 5'd0, 2'd1,1,1, 32'h0, 32'h1, 5'd4, 0,0);
        vecs[8]  = v(0,1,1,0, 32'h1111_1111, 32'h0, 5'd1, 2'd1,1,1,
                     32'h1111_1111, 32'h0, 5'd1, 0,0);
        vecs[9]  = v(0,1,1,1, 32'h0, 32'h8000_0000, 5'd2, 2'd1,1,1,
                     32'h0, 32'h8000_0000, 5'd2, 0,1);
        vecs[10] = v(0,1,1,0, 32'hFFFF_FFFF, 32'h0000_1234, 5'd9, 2'd1,1,1,
                     32'hFFFF_FFFF, 32'h0, 5'd9, 0,1);
        vecs[11] = v(0,1,1,0, 32'h0, 32'h5555_5555, 5'd10, 2'd1,1,1,
                     32'h0, 32'h0, 5'd10, 1,0);
        vecs[12] = v(0,1,1,1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd17, 2'd1,1,1,
                     32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd17, 0,1);
        vecs[13] = v(0,1,1,1, 32'hABCD_0123, 32'h0, 5'd30, 2'd1,1,1,
                     32'hABCD_0123, 32'h0, 5'd30, 0,0);
        vecs[14] = v(0,1,0,0, 32'h2, 32'h0, 5'd5, 2'd2,1,0,
                     32'hABCD_0123, 32'h0, 5'd30, 0,0);
        vecs[15] = v(1,1,1,0, 32'h3, 32'h0, 5'd6, 2'd0,0,1, 32'h0, 32'h0, 5'd0, 0,0);
        vecs[16] = v(0,0,1,0, 32'h0, 32'h0, 5'd0, 2'd0,0,1, 32'h0, 32'h0, 5'd0, 0,0);
        vecs[17] = v(0,1,0,0, 32'hAA, 32'h0, 5'd6, 2'd1,1,1, 32'hAA, 32'h0, 5'd6, 0,0);

        for (int i = 0; i < int'(NVEC); i++) begin
            clear = vecs[i].clr; in_valid = vecs[i].iv; out_ready = vecs[i].ordy;
            in_wide = vecs[i].wide; in_lo = vecs[i].lo; in_hi = vecs[i].hi; in_op = vecs[i].op;
            @(posedge clock);
            #1;
            got = pack_out(count, out_valid, in_ready, out_lo, out_hi, out_op, out_zero, out_neg);
            exp = pack_out(vecs[i].e_cnt, vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_lo,
                           vecs[i].e_hi, vecs[i].e_op, vecs[i].e_z, vecs[i].e_n);
            compare($sformatf("vec%0d", i), got, exp, {76{1'b1}});
        end

        // Randomized traffic against a queue model.
        clear = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clock);
        #1;
        clear = 1'b0;
        sb.delete();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_wide   = $urandom_range(0, 1) == 1;
            in_lo     = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            in_hi     = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            in_op     = 5'($urandom_range(0, 31));
            do_push = in_valid && (sb.size() < int'(DEPTH));
            do_pop  = out_ready && (sb.size() != 0);
            e = model_entry(in_lo, in_hi, in_wide, in_op);
            @(posedge clock);
            #1;
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back(e);
            got = pack_out(count, out_valid, in_ready, out_lo, out_hi, out_op, out_zero, out_neg);
            if (sb.size() != 0) begin
                exp  = pack_out(2'(sb.size()), 1'b1, sb.size() < int'(DEPTH), sb[0].lo,
                                sb[0].hi, sb[0].op, sb[0].z, sb[0].n);
                mask = {76{1'b1}};
            end else begin
                exp  = pack_out(2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
                mask = {4'hF, 72'h0};
            end
            compare($sformatf("rand%0d", c), got, exp, mask);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
